// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dmem port arbiter: default widths, owner encodings, starve counter width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_arb_pkg;

    localparam int ADDR_W_DEF   = 12;
    localparam int DATA_W_DEF   = 32;
    localparam int STARVE_CNT_W = 4;
    localparam int PERF_CNT_W   = 16;

    // Which requester a pending read return belongs to
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam logic [STARVE_CNT_W-1:0] STARVE_SAT = '1;

endpackage

// File: rtl/dmem_arb_perf_ctr.sv
// 16-bit saturating event counter used for arbiter performance statistics.
// Latency: count visible the cycle after the increment strobe.
// Backpressure: none; holds at all-ones once saturated.
module dmem_arb_perf_ctr
    import dmem_arb_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_inc,
    output logic [PERF_CNT_W-1:0] o_cnt
);

    logic [PERF_CNT_W-1:0] r_cnt;

    // Count strobes, sticking at the maximum instead of wrapping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {PERF_CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port dmem: port 0 fixed priority, port 1 forced after STARVE_MAX losses.
// Latency: grant combinational; read data returned one cycle after the read grant edge.
// Backpressure: requester holds its request until it sees gnt. Optional macro DMEM_ARB_PERF_EN adds perf counters.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_W-1:0]     p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p1_rdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [PERF_CNT_W-1:0] perf_p0_grants,
    output logic [PERF_CNT_W-1:0] perf_p1_grants,
    output logic [PERF_CNT_W-1:0] perf_conflicts,
`endif
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_data,
    output logic                  mem_wren,
    input  logic [DATA_W-1:0]     mem_q
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX_C = STARVE_MAX[STARVE_CNT_W-1:0];

    logic [STARVE_CNT_W-1:0] r_starve_cnt;
    logic                    r_rd_pend;
    port_e                   r_rd_owner;
    logic [ADDR_W-1:0]       r_addr_hold;
    logic [DATA_W-1:0]       r_data_hold;
    logic [DATA_W-1:0]       r_p0_rdata;
    logic [DATA_W-1:0]       r_p1_rdata;

    logic                    w_force1;
    logic                    w_p0_gnt;
    logic                    w_p1_gnt;
    logic                    w_any_gnt;
    logic                    w_rd_gnt;
    port_e                   w_gnt_port;
    logic                    w_p0_rvalid;
    logic                    w_p1_rvalid;

    // Grant: port 0 wins unless port 1 has lost too often; reset blocks every grant immediately
    always_comb begin
        w_force1   = (r_starve_cnt >= STARVE_MAX_C);
        w_p1_gnt   = reset & p1_req & (~p0_req | w_force1);
        w_p0_gnt   = reset & p0_req & ~w_p1_gnt;
        w_any_gnt  = w_p0_gnt | w_p1_gnt;
        w_gnt_port = w_p1_gnt ? PORT1 : PORT0;
        w_rd_gnt   = (w_p0_gnt & ~p0_we) | (w_p1_gnt & ~p1_we);
    end

    // Memory-side mux: granted port drives the bus, otherwise the last granted address/data is held
    always_comb begin
        mem_address = r_addr_hold;
        mem_data    = r_data_hold;
        mem_wren    = 1'b0;
        if (w_p1_gnt) begin
            mem_address = p1_addr;
            mem_data    = p1_wdata;
            mem_wren    = p1_we;
        end else if (w_p0_gnt) begin
            mem_address = p0_addr;
            mem_data    = p0_wdata;
            mem_wren    = p0_we;
        end
    end

    // Remember the last granted address/data so the bus stays quiet when idle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr_hold <= '0;
            r_data_hold <= '0;
        end else if (w_any_gnt) begin
            r_addr_hold <= mem_address;
            r_data_hold <= mem_data;
        end
    end

    // Starvation counter: counts port-1 losses, cleared on a port-1 win or when port 1 stops asking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_p1_gnt || !p1_req) begin
            r_starve_cnt <= '0;
        end else if (w_p0_gnt && (r_starve_cnt != STARVE_SAT)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Track the single outstanding read so its data is routed to the right port next cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= PORT0;
        end else begin
            r_rd_pend <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_owner <= w_gnt_port;
            end
        end
    end

    assign w_p0_rvalid = r_rd_pend & (r_rd_owner == PORT0);
    assign w_p1_rvalid = r_rd_pend & (r_rd_owner == PORT1);

    // Capture returned data per port so rdata holds between returns
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else begin
            if (w_p0_rvalid) begin
                r_p0_rdata <= mem_q;
            end
            if (w_p1_rvalid) begin
                r_p1_rdata <= mem_q;
            end
        end
    end

    assign p0_gnt    = w_p0_gnt;
    assign p1_gnt    = w_p1_gnt;
    assign p0_rvalid = w_p0_rvalid;
    assign p1_rvalid = w_p1_rvalid;
    assign p0_rdata  = w_p0_rvalid ? mem_q : r_p0_rdata;
    assign p1_rdata  = w_p1_rvalid ? mem_q : r_p1_rdata;

`ifdef DMEM_ARB_PERF_EN
    logic w_conflict;
    assign w_conflict = p0_req & p1_req;

    dmem_arb_perf_ctr u_perf_p0 (
        .clock (clock),
        .reset (reset),
        .i_inc (w_p0_gnt),
        .o_cnt (perf_p0_grants)
    );

    dmem_arb_perf_ctr u_perf_p1 (
        .clock (clock),
        .reset (reset),
        .i_inc (w_p1_gnt),
        .o_cnt (perf_p1_grants)
    );

    dmem_arb_perf_ctr u_perf_cf (
        .clock (clock),
        .reset (reset),
        .i_inc (w_conflict),
        .o_cnt (perf_conflicts)
    );
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a write-first syncram model behind it.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0]   perf_p0_grants, perf_p1_grants, perf_conflicts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .p0_req      (p0_req),
        .p0_we       (p0_we),
        .p0_addr     (p0_addr),
        .p0_wdata    (p0_wdata),
        .p0_gnt      (p0_gnt),
        .p0_rvalid   (p0_rvalid),
        .p0_rdata    (p0_rdata),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_addr     (p1_addr),
        .p1_wdata    (p1_wdata),
        .p1_gnt      (p1_gnt),
        .p1_rvalid   (p1_rvalid),
        .p1_rdata    (p1_rdata),
`ifdef DMEM_ARB_PERF_EN
        .perf_p0_grants (perf_p0_grants),
        .perf_p1_grants (perf_p1_grants),
        .perf_conflicts (perf_conflicts),
`endif
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port write-first syncram: q reflects the address registered at the edge
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem_wren ? mem_data : mem[mem_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        p0_req = 1'b0; p0_we = 1'b0;
        p1_req = 1'b0; p1_we = 1'b0;
    endtask

    task automatic p0_drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
    endtask

    task automatic p1_drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
    endtask

    logic [9:0] exp_p1_pat;
    int         p1_cnt;

    initial begin
        exp_p1_pat = 10'b10000_10000;
        p1_cnt     = 0;
        reset      = 1'b0;
        p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;
        // Traffic present while reset is low: nothing may be granted
        p0_drive(1'b1, 12'h055, 32'h1111_2222);
        p1_drive(1'b0, 12'h066, 32'h0);
        step();
        step();
        chk("rst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
        chk("rst_p1_gnt", {31'b0, p1_gnt}, 32'd0);
        chk("rst_wren", {31'b0, mem_wren}, 32'd0);
        chk("rst_rvalid", {30'b0, p0_rvalid, p1_rvalid}, 32'd0);
        chk("rst_addr", {20'b0, mem_address}, 32'd0);
        chk("rst_data", mem_data, 32'd0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);

        // Both ports contend for 10 cycles right out of reset: p0 x4, p1 x1, repeating
        p0_drive(1'b1, 12'h100, 32'hAAAA_0000);
        p1_drive(1'b1, 12'h200, 32'hBBBB_0000);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("starve_p1_c%0d", i), {31'b0, p1_gnt}, {31'b0, exp_p1_pat[i]});
            chk($sformatf("starve_p0_c%0d", i), {31'b0, p0_gnt}, {31'b0, ~exp_p1_pat[i]});
            if (p1_gnt) p1_cnt++;
            step();
        end
        chk("starve_p1_total", p1_cnt, 32'd2);
        idle();
`ifdef DMEM_ARB_PERF_EN
        chk("perf_p0", {16'b0, perf_p0_grants}, 32'd8);
        chk("perf_p1", {16'b0, perf_p1_grants}, 32'd2);
        chk("perf_cf", {16'b0, perf_conflicts}, 32'd10);
`endif
        step();

        // p0 writes, then p1 reads the same word
        p0_drive(1'b1, 12'h010, 32'hDEAD_BEEF);
        #1;
        chk("wr_p0_gnt", {31'b0, p0_gnt}, 32'd1);
        chk("wr_wren", {31'b0, mem_wren}, 32'd1);
        chk("wr_addr", {20'b0, mem_address}, 32'h010);
        step();
        idle();
        p1_drive(1'b0, 12'h010, 32'h0);
        #1;
        chk("rd_p1_gnt", {31'b0, p1_gnt}, 32'd1);
        chk("rd_wren", {31'b0, mem_wren}, 32'd0);
        chk("wr_no_rvalid", {31'b0, p0_rvalid}, 32'd0);
        step();
        idle();
        #1;
        chk("rd_p1_rvalid", {31'b0, p1_rvalid}, 32'd1);
        chk("rd_p1_rdata", p1_rdata, 32'hDEAD_BEEF);
        chk("rd_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        chk("idle_addr_hold", {20'b0, mem_address}, 32'h010);
        step();
        chk("rd_p1_rvalid_off", {31'b0, p1_rvalid}, 32'd0);
        chk("rd_p1_rdata_hold", p1_rdata, 32'hDEAD_BEEF);

        // Preload 1..3, then back-to-back p0 reads
        p0_drive(1'b1, 12'h001, 32'hA); step();
        p0_drive(1'b1, 12'h002, 32'hB); step();
        p0_drive(1'b1, 12'h003, 32'hC); step();
        p0_drive(1'b0, 12'h001, 32'h0); step();
        p0_drive(1'b0, 12'h002, 32'h0); #1;
        chk("b2b_rv0", {31'b0, p0_rvalid}, 32'd1);
        chk("b2b_rd0", p0_rdata, 32'hA);
        step();
        p0_drive(1'b0, 12'h003, 32'h0); #1;
        chk("b2b_rv1", {31'b0, p0_rvalid}, 32'd1);
        chk("b2b_rd1", p0_rdata, 32'hB);
        step();
        idle(); #1;
        chk("b2b_rv2", {31'b0, p0_rvalid}, 32'd1);
        chk("b2b_rd2", p0_rdata, 32'hC);
        chk("b2b_p1_quiet", {31'b0, p1_rvalid}, 32'd0);
        step();
        chk("b2b_end", {31'b0, p0_rvalid}, 32'd0);

        // Write then read of the same address on consecutive cycles returns the new value
        p0_drive(1'b1, 12'h020, 32'h1234_5678); step();
        p0_drive(1'b0, 12'h020, 32'h0); step();
        idle(); #1;
        chk("wf_rvalid", {31'b0, p0_rvalid}, 32'd1);
        chk("wf_rdata", p0_rdata, 32'h1234_5678);
        step();

        // Read granted, then reset pulsed before the next edge: the return is dropped
        p0_drive(1'b0, 12'h001, 32'h0);
        #1;
        chk("rr_gnt", {31'b0, p0_gnt}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("rr_gnt_in_rst", {31'b0, p0_gnt}, 32'd0);
        idle();
        reset = 1'b1;
        step();
        chk("rr_no_rv_a", {30'b0, p0_rvalid, p1_rvalid}, 32'd0);
        step();
        chk("rr_no_rv_b", {30'b0, p0_rvalid, p1_rvalid}, 32'd0);
        // First grant after reset behaves as from idle
        p0_drive(1'b1, 12'h030, 32'h5);
        p1_drive(1'b1, 12'h031, 32'h6);
        #1;
        chk("post_rst_p0", {31'b0, p0_gnt}, 32'd1);
        chk("post_rst_p1", {31'b0, p1_gnt}, 32'd0);
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
